pipeline_catcher: RTL

PIPELINE_CATCHER -- requirements
Module: pipeline_catcher

---
 rtl/pipeline_catcher_pkg.sv | 13 +
 rtl/pipeline_catcher_catch_fifo.sv | 66 ++++++
 rtl/pipeline_catcher.sv | 76 +++++++
 3 files changed

// File: rtl/pipeline_catcher_pkg.sv
// Shared defaults and a pointer-wrap helper for the pipeline catcher slice.
// DEPTH need not be a power of two, so pointers wrap explicitly.
package pipeline_catcher_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_LATENCY = 4;
  localparam int unsigned DEFAULT_DEPTH   = 8;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return ((ptr + 1) >= depth) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/pipeline_catcher_catch_fifo.sv
// Catch buffer: first-word fall-through FIFO that never stalls its writer.
// A write arriving while full with no pop in the same cycle is dropped and flagged.
module catch_fifo
  import pipeline_catcher_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_write;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_rd_ready && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full buffer may still accept.
  assign w_write = i_wr_valid && (!w_full || w_pop);
  assign o_drop  = i_wr_valid && w_full && !w_pop;

  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
      end
      if (w_pop) begin
        r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_catcher.sv
// Credit front-end for a fixed-latency, non-stallable pipeline: launches are
// only allowed while every in-flight and stored item is guaranteed a buffer slot.
module pipeline_catcher
  import pipeline_catcher_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       ret_valid,
  input  logic [WIDTH-1:0]           ret_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  generate
    if (LATENCY < 1 || DEPTH < 1) begin : g_bad_params
      $error("pipeline_catcher: LATENCY and DEPTH must both be at least 1");
    end
  endgenerate

  logic [OCC_W-1:0] r_occupancy;
  logic             r_overflow;

  logic w_fire;
  logic w_pop;
  logic w_drop;

  assign issue_ready = (r_occupancy < OCC_W'(DEPTH));
  assign w_fire      = issue_valid && issue_ready;
  assign w_pop       = out_valid && out_ready;
  assign occupancy   = r_occupancy;
  assign overflow    = r_overflow;

  catch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_catch_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (ret_valid),
    .i_wr_data  (ret_data),
    .i_rd_ready (out_ready),
    .o_rd_valid (out_valid),
    .o_rd_data  (out_data),
    .o_drop     (w_drop)
  );

  // Occupancy counts both in-flight and stored items; the decrement saturates
  // because stray returns can leave stored items the credits never covered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occupancy <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_fire && !w_pop) begin
        r_occupancy <= r_occupancy + OCC_W'(1);
      end else if (!w_fire && w_pop && (r_occupancy != '0)) begin
        r_occupancy <= r_occupancy - OCC_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
